// File: rtl/cbus_rr_arbiter_pkg.sv
// Shared cbus types for the cache-side bus and its round-robin arbiter.
// Request and response layouts match the existing cbus masters and AXI adapter.
package cbus_rr_arbiter_pkg;

   typedef enum logic [7:0] {
      MLEN1  = 8'd0,
      MLEN2  = 8'd1,
      MLEN4  = 8'd3,
      MLEN8  = 8'd7,
      MLEN16 = 8'd15
   } cbus_len_t;

   typedef enum logic [1:0] {
      AXI_BURST_FIXED = 2'd0,
      AXI_BURST_INCR  = 2'd1,
      AXI_BURST_WRAP  = 2'd2
   } cbus_burst_t;

   // 151 bits
   typedef struct packed {
      logic        valid;
      logic        is_write;
      logic [2:0]  size;
      logic [63:0] addr;
      logic [7:0]  strobe;
      logic [63:0] data;
      cbus_len_t   len;
      cbus_burst_t burst;
   } cbus_req_t;

   // 66 bits
   typedef struct packed {
      logic        ready;
      logic        last;
      logic [63:0] data;
   } cbus_resp_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } arb_state_t;

   // Modular wrap used by the rotating priority search.
   function automatic int rr_wrap(input int i, input int n);
      return i % n;
   endfunction

endpackage

// File: rtl/cbus_rr_arbiter_rr_picker.sv
// Round-robin picker: rotate the request vector to start just after the
// last winner, priority-encode, then map the offset back to a master index.
module rr_picker
   import cbus_rr_arbiter_pkg::*;
#(
   parameter  int N     = 2,
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     i_valid,
   input  logic [IDX_W-1:0] i_last_idx,
   output logic             o_found,
   output logic [IDX_W-1:0] o_pick_idx
);

   logic [N-1:0]     w_rot;
   logic [IDX_W-1:0] w_off;

   // Rotate so that bit 0 is the master right after the last winner.
   always_comb begin
      w_rot = '0;
      for (int k = 0; k < N; k++) begin
         w_rot[IDX_W'(k)] =
            i_valid[IDX_W'(rr_wrap(int'(i_last_idx) + 1 + k, N))];
      end
   end

   // Lowest set bit of the rotated vector wins.
   always_comb begin
      o_found = 1'b0;
      w_off   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_rot[IDX_W'(k)]) begin
            o_found = 1'b1;
            w_off   = IDX_W'(k);
         end
      end
   end

   // Undo the rotation to recover the absolute master index.
   always_comb begin
      o_pick_idx =
         IDX_W'(rr_wrap(int'(i_last_idx) + 1 + int'(w_off), N));
   end

endmodule

// File: rtl/cbus_rr_arbiter.sv
// Round-robin arbiter merging cache-side cbus masters onto one memory port.
// A grant is held for a whole burst; at least one idle cycle separates bursts.
module cbus_rr_arbiter
   import cbus_rr_arbiter_pkg::*;
#(
   parameter  int NUM_MASTERS = 2,
   localparam int IDX_W       = $clog2(NUM_MASTERS)
) (
   input  logic       clk,
   input  logic       reset,
   input  cbus_req_t  ireqs  [NUM_MASTERS],
   output cbus_resp_t iresps [NUM_MASTERS],
   output cbus_req_t  oreq,
   input  cbus_resp_t oresp
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   logic [IDX_W-1:0] r_grant_idx;
   logic [IDX_W-1:0] w_grant_nxt;
   logic [IDX_W-1:0] r_last_idx;
   logic [IDX_W-1:0] w_last_nxt;

   logic [NUM_MASTERS-1:0] w_valid;
   logic                   w_found;
   logic [IDX_W-1:0]       w_pick_idx;
   cbus_req_t              w_cur;
   logic                   w_done;

   // Collect the valid bits for the picker.
   always_comb begin
      w_valid = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         w_valid[i] = ireqs[i].valid;
      end
   end

   rr_picker #(
      .N (NUM_MASTERS)
   ) u_picker (
      .i_valid    (w_valid),
      .i_last_idx (r_last_idx),
      .o_found    (w_found),
      .o_pick_idx (w_pick_idx)
   );

   // Burst ends on the last handshake or when the owner drops valid.
   always_comb begin
      w_cur  = ireqs[r_grant_idx];
      w_done = (oresp.ready && oresp.last) || !w_cur.valid;
   end

   // State, grant and round-robin pointer registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_grant_idx <= '0;
         r_last_idx  <= IDX_W'(NUM_MASTERS - 1);
      end else begin
         r_state     <= w_state_nxt;
         r_grant_idx <= w_grant_nxt;
         r_last_idx  <= w_last_nxt;
      end
   end

   // Next-state: grant from IDLE, release the grant at end of burst.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant_idx;
      w_last_nxt  = r_last_idx;
      unique case (r_state)
         IDLE: begin
            if (w_found) begin
               w_state_nxt = BUSY;
               w_grant_nxt = w_pick_idx;
            end
         end
         BUSY: begin
            if (w_done) begin
               w_state_nxt = IDLE;
               w_last_nxt  = r_grant_idx;
            end
         end
      endcase
   end

   // Pass the granted master through; everyone else sees an idle response.
   always_comb begin
      oreq = '0;
      for (int i = 0; i < NUM_MASTERS; i++) begin
         iresps[i] = '0;
      end
      if (r_state == BUSY) begin
         oreq                = w_cur;
         iresps[r_grant_idx] = oresp;
      end
   end

endmodule

// File: tb/tb_cbus_rr_arbiter.sv
// Self-checking bench for cbus_rr_arbiter (2- and 3-master instances).
// Response beats are scoreboarded from the memory side to the masters.
module tb_cbus_rr_arbiter;
   import cbus_rr_arbiter_pkg::*;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   cbus_req_t  ireqs2  [2];
   cbus_resp_t iresps2 [2];
   cbus_req_t  oreq2;
   cbus_resp_t oresp2;

   cbus_req_t  ireqs3  [3];
   cbus_resp_t iresps3 [3];
   cbus_req_t  oreq3;
   cbus_resp_t oresp3;

   cbus_rr_arbiter #(.NUM_MASTERS(2)) dut2 (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs2),
      .iresps (iresps2),
      .oreq   (oreq2),
      .oresp  (oresp2)
   );

   cbus_rr_arbiter #(.NUM_MASTERS(3)) dut3 (
      .clk    (clk),
      .reset  (reset),
      .ireqs  (ireqs3),
      .iresps (iresps3),
      .oreq   (oreq3),
      .oresp  (oresp3)
   );

   typedef struct {
      int          m;
      logic [63:0] data;
      logic        last;
   } sb_t;

   sb_t sb_q[$];
   int  n_checks = 0;
   int  n_errors = 0;

   logic [63:0] addrs [3] = '{64'h8000_1000, 64'h8000_0040, 64'h8000_2000};

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic mk_req(input int m, output cbus_req_t r);
      r        = '0;
      r.valid  = 1'b1;
      r.size   = 3'd3;
      r.addr   = addrs[m];
      r.strobe = 8'hff;
      r.len    = MLEN8;
      r.burst  = AXI_BURST_INCR;
   endtask

   task automatic set_req2(input int m);
      cbus_req_t r;
      mk_req(m, r);
      ireqs2[m] = r;
   endtask

   task automatic set_req3(input int m);
      cbus_req_t r;
      mk_req(m, r);
      ireqs3[m] = r;
   endtask

   // Pop one expected beat per ready seen by any master.
   task automatic sample2();
      sb_t e;
      for (int i = 0; i < 2; i++) begin
         if (iresps2[i].ready) begin
            if (sb_q.size() == 0) begin
               chk("sb_unexpected_ready", 64'(i), 64'hdead);
            end else begin
               e = sb_q.pop_front();
               chk("resp_master", 64'(i), 64'(e.m));
               chk("resp_data", iresps2[i].data, e.data);
               chk("resp_last", 64'(iresps2[i].last), 64'(e.last));
            end
         end
      end
      chk("sb_drain", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic do_burst2(input int m, input int nbeats, input bit keep,
                            input int abort_at, input int rst_at);
      bit seen;
      seen = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (oreq2.valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("grant_seen", 64'(seen), 64'd1);
      if (!seen) return;
      chk("grant_addr", oreq2.addr, addrs[m]);
      for (int b = 0; b < nbeats; b++) begin
         @(posedge clk);
         #1;
         if (b == abort_at) begin
            ireqs2[m].valid = 1'b0;
            @(negedge clk);
            chk("abort_valid", 64'(oreq2.valid), 64'd0);
            return;
         end
         ireqs2[m].data   = {$urandom, $urandom};
         ireqs2[m].strobe = 8'($urandom);
         oresp2.ready     = 1'b1;
         oresp2.last      = (b == nbeats - 1);
         oresp2.data      = {$urandom, $urandom};
         sb_q.push_back('{m, oresp2.data, oresp2.last});
         @(negedge clk);
         chk("beat_valid", 64'(oreq2.valid), 64'd1);
         chk("beat_data", oreq2.data, ireqs2[m].data);
         chk("beat_strobe", 64'(oreq2.strobe), 64'(ireqs2[m].strobe));
         sample2();
         if (b == rst_at) begin
            #1 reset = 1'b1;
            #1;
            chk("rst_valid", 64'(oreq2.valid), 64'd0);
            chk("rst_resp", 64'(iresps2[m].ready), 64'd0);
            @(posedge clk);
            #1;
            oresp2 = '0;
            reset  = 1'b0;
            return;
         end
      end
      @(posedge clk);
      #1;
      oresp2 = '0;
      if (!keep) ireqs2[m].valid = 1'b0;
      @(negedge clk);
      chk("idle_gap", 64'(oreq2.valid), 64'd0);
   endtask

   task automatic burst3(input int m);
      bit          seen;
      logic [63:0] d;
      seen = 1'b0;
      for (int t = 0; t < 10; t++) begin
         @(negedge clk);
         if (oreq3.valid) begin
            seen = 1'b1;
            break;
         end
      end
      chk("n3_grant_seen", 64'(seen), 64'd1);
      if (!seen) return;
      chk("n3_grant_addr", oreq3.addr, addrs[m]);
      @(posedge clk);
      #1;
      d            = {$urandom, $urandom};
      oresp3.ready = 1'b1;
      oresp3.last  = 1'b1;
      oresp3.data  = d;
      @(negedge clk);
      for (int j = 0; j < 3; j++) begin
         chk("n3_ready", 64'(iresps3[j].ready), 64'(j == m));
      end
      chk("n3_data", iresps3[m].data, d);
      @(posedge clk);
      #1;
      oresp3 = '0;
      @(negedge clk);
      chk("n3_idle_gap", 64'(oreq3.valid), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 2; i++) ireqs2[i] = '0;
      for (int i = 0; i < 3; i++) ireqs3[i] = '0;
      oresp2 = '0;
      oresp3 = '0;
      reset  = 1'b1;

      // Reset held with master 0 requesting
      set_req2(0);
      oresp2.ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_oreq_valid", 64'(oreq2.valid), 64'd0);
      chk("rst_iresp0", 64'(iresps2[0]), 64'd0);
      chk("rst_iresp1", 64'(iresps2[1]), 64'd0);
      @(posedge clk);
      #1;
      reset  = 1'b0;
      oresp2 = '0;
      @(negedge clk);
      chk("rel_idle_cycle", 64'(oreq2.valid), 64'd0);
      @(negedge clk);
      chk("rel_grant_valid", 64'(oreq2.valid), 64'd1);
      chk("rel_grant_addr", oreq2.addr, addrs[0]);
      do_burst2(0, 1, 1'b0, -1, -1);

      // Single 16-beat burst from master 1
      set_req2(1);
      ireqs2[1].len = MLEN16;
      do_burst2(1, 16, 1'b0, -1, -1);

      // Contention: alternate grants
      set_req2(0);
      set_req2(1);
      do_burst2(0, 2, 1'b1, -1, -1);
      do_burst2(1, 2, 1'b1, -1, -1);
      do_burst2(0, 2, 1'b1, -1, -1);
      do_burst2(1, 2, 1'b0, -1, -1);

      // Abort of master 0 after 3 of 8 beats, master 1 waiting
      set_req2(1);
      do_burst2(0, 8, 1'b0, 3, -1);
      do_burst2(1, 2, 1'b0, -1, -1);

      // Move pointer to master 0, then reset mid-burst of master 1
      set_req2(0);
      do_burst2(0, 1, 1'b0, -1, -1);
      set_req2(0);
      set_req2(1);
      do_burst2(1, 8, 1'b1, -1, 4);
      do_burst2(0, 1, 1'b0, -1, -1);
      do_burst2(1, 1, 1'b0, -1, -1);

      // Three masters: 0 and 2 requesting, then 1 joins
      set_req3(0);
      set_req3(2);
      burst3(0);
      burst3(2);
      burst3(0);
      set_req3(1);
      burst3(1);
      ireqs3[0].valid = 1'b0;
      ireqs3[1].valid = 1'b0;
      ireqs3[2].valid = 1'b0;

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
